// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO for the 16550-style UART: THR writes in, serializer pops on the falling edge of its level request.
// Optional FIFO trigger-level output is compiled in with `define UART_TX_FIFO_TRIG_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
`ifdef UART_TX_FIFO_TRIG_EN
    ,
    input  logic [1:0]               trig_sel,
    output logic                     trig
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop_q;
    logic             pop_fe;
    logic             do_consume;
    logic             do_push;
    logic             drop;
    logic [CW-1:0]    count_next;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = empty ? '0 : mem[rd_ptr];

    // The head word is held for the whole pop pulse; only its falling edge consumes.
    assign pop_fe     = pop_q & ~pop;
    assign do_consume = pop_fe & ~empty;
    assign do_push    = push & (~full | do_consume);
    assign drop       = push & full & ~do_consume;

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (do_push && !do_consume)
            count_next = count + CW'(1);
        else if (!do_push && do_consume)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pop_q <= 1'b0;
        else
            pop_q <= pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            count <= count_next;
            if (do_consume)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (drop)
                overrun <= 1'b1;
        end
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= din;
    end

`ifdef UART_TX_FIFO_TRIG_EN
    logic [31:0] level;

    always_comb begin
        level = 32'd1;
        case (trig_sel)
            2'b00: level = 32'd1;
            2'b01: level = 32'd4;
            2'b10: level = 32'd8;
            2'b11: level = 32'd14;
            default: level = 32'd1;
        endcase
    end

    // Registered alongside count so trig tracks the new occupancy without a lag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            trig <= 1'b0;
        else
            trig <= (32'(count_next) >= level);
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic against a queue-based model.
// Trigger checks are included when UART_TX_FIFO_TRIG_EN is defined.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             push;
    logic [WIDTH-1:0] din;
    logic             pop;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic [4:0]       count;
    logic             overrun;
`ifdef UART_TX_FIFO_TRIG_EN
    logic [1:0]       trig_sel;
    logic             trig;
`endif

    int checks;
    int failures;

    logic [WIDTH-1:0] q[$];
    bit               model_ovr;
    bit               pop_prev;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .push(push),
        .din(din),
        .pop(pop),
        .dout(dout),
        .empty(empty),
        .full(full),
        .count(count),
        .overrun(overrun)
`ifdef UART_TX_FIFO_TRIG_EN
        ,
        .trig_sel(trig_sel),
        .trig(trig)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        model_ovr = 0;
        pop_prev  = 0;
    endtask

    // One clock of the reference behaviour: falling edge of pop consumes a word, push appends.
    task automatic modelStep(input logic p, input logic [WIDTH-1:0] d, input logic po, input logic c);
        bit consume;
        consume  = pop_prev && !po && (q.size() > 0);
        pop_prev = po;
        if (c) begin
            q.delete();
            model_ovr = 0;
        end else begin
            if (consume)
                void'(q.pop_front());
            if (p) begin
                if (q.size() < DEPTH)
                    q.push_back(d);
                else
                    model_ovr = 1;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        int n;
        n = q.size();
        checkOutput({tag, ".empty"}, 32'(empty), 32'(n == 0));
        checkOutput({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        checkOutput({tag, ".count"}, 32'(count), 32'(n));
        checkOutput({tag, ".dout"}, 32'(dout), (n == 0) ? 32'd0 : 32'(q[0]));
        checkOutput({tag, ".overrun"}, 32'(overrun), 32'(model_ovr));
`ifdef UART_TX_FIFO_TRIG_EN
        begin
            int lvl;
            case (trig_sel)
                2'b00: lvl = 1;
                2'b01: lvl = 4;
                2'b10: lvl = 8;
                default: lvl = 14;
            endcase
            checkOutput({tag, ".trig"}, 32'(trig), 32'(n >= lvl));
        end
`endif
    endtask

    task automatic applyStimulus(input string tag, input logic p, input logic [WIDTH-1:0] d,
                                 input logic po, input logic c);
        @(negedge clk);
        push = p;
        din  = d;
        pop  = po;
        clr  = c;
        @(posedge clk);
        modelStep(p, d, po, c);
        #1;
        checkAll(tag);
    endtask

    task automatic popPulse(input string tag);
        applyStimulus(tag, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b0;
        clr  = 1'b0;
        push = 1'b0;
        din  = '0;
        pop  = 1'b0;
`ifdef UART_TX_FIFO_TRIG_EN
        trig_sel = 2'b00;
`endif
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single word held through a long pop, consumed only when pop drops
        applyStimulus("a5_push", 1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("a5_head", 32'(dout), 32'hA5);
        for (int i = 0; i < 16; i++) begin
            applyStimulus("a5_hold", 1'b0, '0, 1'b1, 1'b0);
            checkOutput("a5_stable", 32'(dout), 32'hA5);
        end
        applyStimulus("a5_drop", 1'b0, '0, 1'b0, 1'b0);
        checkOutput("a5_gone", 32'(empty), 32'd1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++)
            applyStimulus("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        applyStimulus("ovf", 1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("ovf_flag", 32'(overrun), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_order", 32'(dout), 32'(i));
            popPulse("drain");
        end

        // Push accepted against a simultaneous consume while full
        applyStimulus("clr0", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            applyStimulus("fill2", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        applyStimulus("full_pop_hi", 1'b0, '0, 1'b1, 1'b0);
        applyStimulus("full_pop_fe", 1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput("full_swap_ovr", 32'(overrun), 32'd0);
        checkOutput("full_swap_count", 32'(count), 32'd16);
        for (int i = 0; i < 15; i++)
            popPulse("drain2");
        checkOutput("last_77", 32'(dout), 32'h77);
        popPulse("drain2_last");

        // Underflow attempts are harmless
        for (int i = 0; i < 3; i++)
            popPulse("underflow");
        applyStimulus("push_3c", 1'b1, 8'h3C, 1'b0, 1'b0);
        checkOutput("u_dout", 32'(dout), 32'h3C);
        checkOutput("u_count", 32'(count), 32'd1);

        // clr beats a simultaneous push, then async reset mid-burst
        for (int i = 0; i < 10; i++)
            applyStimulus("fill10", 1'b1, 8'($urandom), 1'b0, 1'b0);
        applyStimulus("clr_push", 1'b1, 8'hEE, 1'b0, 1'b1);
        checkOutput("clr_count", 32'(count), 32'd0);
        for (int i = 0; i < 6; i++)
            applyStimulus("burst", 1'b1, 8'($urandom), 1'b0, 1'b0);
        applyStimulus("burst_ovf", 1'b0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        checkAll("async_rst");
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        rst  = 1'b1;

`ifdef UART_TX_FIFO_TRIG_EN
        trig_sel = 2'b01;
        for (int i = 0; i < 3; i++)
            applyStimulus("trig_fill", 1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("trig_at3", 32'(trig), 32'd0);
        applyStimulus("trig_fill4", 1'b1, 8'h03, 1'b0, 1'b0);
        checkOutput("trig_at4", 32'(trig), 32'd1);
        applyStimulus("trig_clr", 1'b0, '0, 1'b0, 1'b1);
`endif

        // Pointer roll-over with interleaved push and consume
        for (int i = 0; i < 40; i++) begin
            applyStimulus("wrap_push", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            applyStimulus("wrap_pop", 1'b0, '0, 1'b0, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic p, po, c;
            p  = ($urandom_range(0, 9) < 5);
            po = (i % 40 < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 99) < 2);
`ifdef UART_TX_FIFO_TRIG_EN
            if ($urandom_range(0, 15) == 0)
                trig_sel = 2'($urandom);
`endif
            applyStimulus("rand", p, 8'($urandom), po, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

16-entry by 8-bit transmit holding FIFO for the 16550-compatible UART. It sits between the register-file write path (THR writes) and the transmit serializer. It presents the head word combinationally on `dout` and flags `empty` as the THRE status the serializer polls. It accepts the serializer's level-style `pop` request and consumes exactly one word per request.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, 2..256.
- `WIDTH`, 8: data word width.

Ports. One clock; reset is asynchronous and active-low.
- `clk`, in, 1: system clock; all state updates on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous flush (FCR TX-FIFO reset bit); one-cycle pulse.
- `push`, in, 1: write strobe; one word accepted per cycle in which it is high.
- `din`, in, WIDTH: write data, sampled with `push`.
- `pop`, in, 1: level request from the serializer; may stay high for many cycles.
- `dout`, out, WIDTH: head-of-queue word; 0 when `empty`.
- `empty`, out, 1: no words stored (drives LSR THRE).
- `full`, out, 1: DEPTH words stored.
- `count`, out, log2(DEPTH)+1: number of stored words.
- `overrun`, out, 1: sticky; set by a push that was dropped.
- `trig_sel`, in, 2: trigger level select: 00→1, 01→4, 10→8, 11→14 (compiled only with macro).
- `trig`, out, 1: `count >= level` (compiled only with macro).

## Operation
- Storage: register array, not reset. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is held separately.
- `dout` is `mem[rd_ptr]` when `!empty`, otherwise 0. It is a combinational mux from registered state, so there is no read latency.
- Pop detection: `pop_q` is registered `pop`. A consume event `pop_fe = pop_q & ~pop` is the falling edge of `pop`. The head word therefore stays stable for the entire time `pop` is high, while the serializer captures it and computes parity. Exactly one word is consumed per high pulse, regardless of pulse length.
- Consume when `empty`: ignored. Pointers and `count` are unchanged and no error is flagged.
- Push when `!full`: write `mem[wr_ptr]`, then `wr_ptr+1` and `count+1`.
- Push when `full` without a simultaneous consume: the word is dropped, `overrun` is set to 1, and storage is unchanged.
- Push and consume in the same cycle:
  - Both take effect and `count` is unchanged.
  - When `full`, the push is accepted because the consume frees a slot, and `overrun` is not set.
  - When `empty`, the push is accepted and the consume is ignored; `count` becomes 1.
- `clr` has priority over push and consume in the same cycle. It zeroes both pointers, `count` and `overrun`. It does not touch `mem` or `pop_q`.
- Flags: `empty = (count==0)`, `full = (count==DEPTH)`. Both are decoded from registered `count`, so there are no glitches across a cycle boundary.

## Timing
- Reset values (`rst`=0): `rd_ptr`=0, `wr_ptr`=0, `count`=0, `pop_q`=0, `overrun`=0. Outputs are therefore `empty`=1, `full`=0, `dout`=0, `trig`=0.
- Reset mid-operation discards all contents immediately (asynchronous). After `rst` deasserts, the first rising edge may accept a push.
- Push at edge k: `empty` falls, `count` increments and `dout` shows the word from cycle k onward (the cycle after the edge). Write-to-head latency is 1 clock.
- `pop` falling: the edge that first samples `pop`=0 performs the consume. `dout` advances to the next word, or 0, and `empty` updates in the following cycle. The consume happens 1 clock after `pop` goes low.
- A `pop` pulse that is high for only one cycle still yields exactly one consume.
- A consume of a full FIFO deasserts `full` 1 clock later.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Sixteen push/consume pairs leave the pointers equal to their start values.
- Maximum sustained rate: one push per clock. Consume rate is one per two clocks minimum (high then low).

## Configuration
- Macro `UART_TX_FIFO_TRIG_EN`.
- Defined: the `trig_sel` and `trig` ports exist. `trig` is a registered compare `count_next >= level(trig_sel)`, updated on the same edge as `count`; it is 0 in reset and after `clr`.
- Undefined: both ports are absent and no compare logic is built. All other behaviour is identical.

## Test plan
- Reset, then push 8'hA5: `empty` 1→0 one cycle later, `dout`=8'hA5, `count`=1. Hold `pop` high 16 clocks: `dout` stays 8'hA5. Drop `pop`: `empty`=1 and `dout`=0 one cycle later.
- Push 0x00..0x0F (16 words): `full`=1, `count`=16. Push 0x55: `overrun`=1, `count` stays 16. Consume 16 times: `dout` sequence is 0x00..0x0F, with no 0x55.
- With `full`=1, assert `push`(8'h77) in the same cycle as a `pop` falling edge: `overrun` stays 0, `count` stays 16, and 8'h77 is the last word out.
- Consume an empty FIFO (3 `pop` pulses), then push 8'h3C: `count`=1 and `dout`=8'h3C, with no underflow corruption.
- Fill 10 words, assert `clr` with a simultaneous `push`: `count`=0, `empty`=1, `overrun`=0. Then assert `rst` low mid-burst: all flags return to reset values asynchronously.
- With `UART_TX_FIFO_TRIG_EN` and `trig_sel`=2'b01: `trig` is 0 at `count`=3 and 1 at `count`=4. Wrap test with 40 push/consume pairs checks order across pointer roll-over.
